// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order queue with flush; head is the oldest entry.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues word fetches, queues responses, feeds decode.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt,
`endif
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if_state_e       state;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_aligned;
  logic [CW-1:0]   outstanding, discard, count, out_nxt;
  logic [CW:0]     in_use;
  fetch_entry_t    head, push_entry;
  logic            accept, rsp_drop, rsp_keep, pop;

  assign redirect_aligned = redirect_pc & ~32'h3;
  // In-flight requests count against the queue so a response always has a slot.
  assign in_use         = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (state == S_RUN) && (in_use < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (redirect_valid || discard != '0);
  assign rsp_keep       = imem_rsp_valid && !rsp_drop;
  assign pop            = if_valid && id_ready && !redirect_valid;
  assign out_nxt        = outstanding + CW'(accept) - CW'(imem_rsp_valid);
  assign push_entry     = '{inst: imem_rsp_data, pc: rsp_pc};

  assign if_valid = (count != '0);
  assign if_inst  = if_valid ? head.inst : NOP_INST;
  assign if_pc    = if_valid ? head.pc   : '0;

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  // rsp_pc tracks the PC of the next kept response; stale ones never advance it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      if (accept)   fetch_pc <= fetch_pc + 32'd4;
      if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        discard  <= out_nxt;
        state    <= (out_nxt != '0) ? S_FLUSH : S_RUN;
      end else begin
        case (state)
          S_BOOT:  state <= S_RUN;
          S_FLUSH: begin
            if (rsp_drop) discard <= discard - 1'b1;
            if (rsp_drop && discard == CW'(1)) state <= S_RUN;
          end
          default: state <= state;
        endcase
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      perf_drop_cnt <= perf_drop_cnt + 32'(rsp_drop) + (redirect_valid ? 32'(count) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model, expected-word scoreboard, immediate assertions.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
  logic        id_ready, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
`endif
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  logic [31:0] exp_pc;
  int          errors = 0, checks = 0;
  int          lat = 1, cyc = 0, q_cnt = 0, n_acc = 0, n_dlv = 0, exp_drop = 0;
  bit          o_req, o_acc, o_dlv, found;
  logic [31:0] o_addr, o_dpc;
  int          n0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] pf0;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample at negedge, update the model.
  task automatic step();
    exp_t  e;
    pend_t p;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    o_req  = imem_req_valid;
    o_addr = imem_addr;
    o_acc  = imem_req_valid && imem_req_ready;
    o_dlv  = if_valid && id_ready && !redirect_valid;
    if (o_req) chk("req_addr", imem_addr, exp_pc);
    if (redirect_valid) chk("no_req_on_redirect", 32'(o_req), 32'd0);
    chk("if_valid", 32'(if_valid), 32'(q_cnt != 0));
    if (!if_valid) chk("nop_when_idle", if_inst, NOP_INST);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(n_dlv));
    chk("perf_drop", perf_drop_cnt, 32'(exp_drop));
`endif
    if (o_dlv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_delivery observed=%h expected=none", if_pc);
      end else begin
        e = sb.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_inst", if_inst, e.inst);
      end
      o_dpc = if_pc;
      n_dlv++;
      q_cnt--;
    end
    if (imem_rsp_valid) begin
      p = pend.pop_front();
      if (p.stale || redirect_valid) exp_drop++;
      else q_cnt++;
    end
    if (redirect_valid) begin
      exp_drop += q_cnt;
      q_cnt = 0;
      foreach (pend[i]) pend[i].stale = 1'b1;
      sb.delete();
      exp_pc = redirect_pc & ~32'h3;
    end
    if (o_acc) begin
      pend.push_back('{addr: exp_pc, due: cyc + lat, stale: 1'b0});
      sb.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
      exp_pc += 32'd4;
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    pend.delete(); sb.delete();
    q_cnt = 0; exp_pc = 32'h0; n_dlv = 0; exp_drop = 0;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_inst", if_inst, NOP_INST);
    chk("rst_if_pc", if_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_drop", perf_drop_cnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Streaming fetch, latency 1, decode always ready
    reset_dut();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    step(); chk("boot_no_req", 32'(o_req), 32'd0);
    step(); chk("first_req", 32'(o_req), 32'd1); chk("first_addr", o_addr, 32'h0);
    repeat (3) step();
    n0 = n_dlv;
    repeat (10) step();
    chk("one_per_cycle", 32'(n_dlv - n0), 32'd10);

    // Decode stalled: issue stops at queue depth, then drains in order
    reset_dut();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    n0 = n_acc;
    repeat (10) step();
    chk("four_reqs", 32'(n_acc - n0), 32'd4);
    chk("full_no_req", 32'(o_req), 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_dlv", 32'(o_dlv), 32'd1);
      chk("drain_pc", o_dpc, 32'(i * 4));
    end

    // One queued entry + 3 in flight, redirect with same-cycle decode handshake
    reset_dut();
    lat = 4; id_ready = 1'b0; imem_req_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    repeat (4) step();
    imem_req_ready = 1'b1;
    n0 = n_acc;
    repeat (3) step();
    chk("three_in_flight", 32'(n_acc - n0), 32'd3);
`ifdef IF_PERF_CNT_EN
    pf0 = perf_fetch_cnt;
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
    step();
    chk("redirect_beats_handshake", 32'(o_dlv), 32'd0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_req", 32'(o_req), 32'd0);
    end
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_unchanged", perf_fetch_cnt, pf0);
    chk("drop_cnt_4", perf_drop_cnt, 32'd4);
`endif
    step();
    chk("post_flush_req", 32'(o_req), 32'd1);
    chk("post_flush_addr", o_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (o_dlv) found = 1'b1;
    end
    chk("dlv_after_redirect_seen", 32'(found), 32'd1);
    chk("first_pc_after_redirect", o_dpc, 32'h100);

    // Misaligned redirect target, then wrap past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (o_req) found = 1'b1;
    end
    chk("aligned_req_seen", 32'(found), 32'd1);
    chk("aligned_addr", o_addr, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (o_acc) found = 1'b1;
    end
    chk("top_req_seen", 32'(found), 32'd1);
    chk("top_addr", o_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_req", 32'(o_acc), 32'd1);
    chk("wrap_addr", o_addr, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (o_dlv) found = 1'b1;
    end
    chk("top_dlv_seen", 32'(found), 32'd1);
    chk("top_dlv_pc", o_dpc, 32'hFFFF_FFFC);
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
